// File: rtl/manual_drive_ctrl.sv
// Manual-drive car controller: power sequencing, engine/driving FSM,
// blinking turn indicators and a saturating odometer on one clock.
module manual_drive_ctrl #(
  parameter int CLK_PER_MS  = 100000,
  parameter int POWER_ON_MS = 1000,
  parameter int IDLE_MS     = 10000,
  parameter int BLINK_MS    = 500,
  parameter int MILEAGE_MS  = 1000,
  parameter int MILEAGE_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 power_on,
  input  logic                 power_off,
  input  logic                 clutch,
  input  logic                 brake,
  input  logic                 throttle,
  input  logic                 rgs,
  input  logic                 left,
  input  logic                 right,
  output logic                 power,
  output logic [1:0]           state,
  output logic [3:0]           moving_state,
  output logic                 turn_left_light,
  output logic                 turn_right_light,
  output logic                 power_light,
  output logic [2:0]           state_light,
  output logic [3:0]           moving_light,
  output logic [MILEAGE_W-1:0] mileage
);

  // state  | meaning
  // NSTART | powered, engine not started, indicators steady on
  // START  | engine running, car stationary
  // MOVING | driving, moving_state holds the direction
  typedef enum logic [1:0] {
    NSTART = 2'b00,
    START  = 2'b01,
    MOVING = 2'b10
  } state_t;

  localparam logic [3:0] MV_NONE  = 4'b0000;
  localparam logic [3:0] MV_FWD   = 4'b0001;
  localparam logic [3:0] MV_BACK  = 4'b0010;
  localparam logic [3:0] MV_LEFT  = 4'b0100;
  localparam logic [3:0] MV_RIGHT = 4'b1000;

  localparam int PW = $clog2(CLK_PER_MS + 1);
  localparam int HW = $clog2(POWER_ON_MS + 1);
  localparam int IW = $clog2(IDLE_MS + 1);
  localparam int BW = $clog2(BLINK_MS + 1);
  localparam int SW = $clog2(MILEAGE_MS + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(POWER_ON_MS - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_MS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);
  localparam logic [SW-1:0] SUB_LAST   = SW'(MILEAGE_MS - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic [HW-1:0] hold_cnt;
  logic [IW-1:0] idle_cnt;
  logic [BW-1:0] blink_cnt;
  logic [SW-1:0] sub_cnt;
  state_t        st;
  logic          blink_l, blink_r, blink_on;
  logic [3:0]    dir;
  logic          dir_l, dir_r;
  logic          hold_hit, idle_hit, stall, pwr_down;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign tick = (presc == PRESC_LAST);

  always_comb begin
    dir = MV_FWD;
    if (rgs) begin
      dir = MV_BACK;
    end else if (left && !right) begin
      dir = MV_LEFT;
    end else if (right && !left) begin
      dir = MV_RIGHT;
    end
  end

  // Forward with both stalks set is the hazard case: both sides blink.
  assign dir_l = (dir == MV_LEFT)  || ((dir == MV_FWD) && left && right);
  assign dir_r = (dir == MV_RIGHT) || ((dir == MV_FWD) && left && right);

  assign hold_hit = !power && power_on && tick && (hold_cnt == HOLD_LAST);
  assign idle_hit = tick && !throttle && (st != MOVING) && (idle_cnt == IDLE_LAST);
  assign stall    = ((st == NSTART) && throttle && !clutch) ||
                    ((st == MOVING) && rgs && !clutch);
  assign pwr_down = power && (power_off || stall || idle_hit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt <= '0;
    end else if (power || !power_on || hold_hit) begin
      hold_cnt <= '0;
    end else if (tick) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if (!power || throttle || (st == MOVING) || pwr_down) begin
      idle_cnt <= '0;
    end else if (tick) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // The sub-counter holds while stopped so partial distance is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sub_cnt <= '0;
      mileage <= '0;
    end else if (tick && (st == MOVING) && (moving_state != MV_NONE)) begin
      if (sub_cnt == SUB_LAST) begin
        sub_cnt <= '0;
        if (mileage != '1) begin
          mileage <= mileage + 1'b1;
        end
      end else begin
        sub_cnt <= sub_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      power        <= 1'b0;
      st           <= NSTART;
      moving_state <= MV_NONE;
      blink_l      <= 1'b0;
      blink_r      <= 1'b0;
      blink_on     <= 1'b0;
      blink_cnt    <= '0;
    end else begin
      blink_l   <= 1'b0;
      blink_r   <= 1'b0;
      blink_cnt <= '0;
      if (!power) begin
        if (hold_hit) begin
          power        <= 1'b1;
          st           <= NSTART;
          moving_state <= MV_NONE;
        end
      end else if (pwr_down) begin
        power        <= 1'b0;
        st           <= NSTART;
        moving_state <= MV_NONE;
      end else if (st == NSTART) begin
        moving_state <= MV_NONE;
        if (!brake && throttle && clutch && !rgs) begin
          st <= START;
        end
      end else if (brake) begin
        st           <= NSTART;
        moving_state <= MV_NONE;
      end else if (((st == START) && !(throttle && !clutch)) ||
                   ((st == MOVING) && !throttle)) begin
        st           <= START;
        moving_state <= MV_NONE;
      end else begin
        st           <= MOVING;
        moving_state <= dir;
        blink_l      <= dir_l;
        blink_r      <= dir_r;
        // A new blink pattern always starts in the lit phase.
        if (dir_l || dir_r) begin
          if ((dir_l != blink_l) || (dir_r != blink_r)) begin
            blink_on <= 1'b1;
          end else if (tick) begin
            if (blink_cnt == BLINK_LAST) begin
              blink_on <= ~blink_on;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end else begin
            blink_cnt <= blink_cnt;
          end
        end
      end
    end
  end

  assign state            = st;
  assign power_light      = power;
  assign moving_light     = power ? moving_state : MV_NONE;
  assign turn_left_light  = power && ((st == NSTART) || (blink_l && blink_on));
  assign turn_right_light = power && ((st == NSTART) || (blink_r && blink_on));

  always_comb begin
    state_light = 3'b000;
    if (power) begin
      case (st)
        NSTART:  state_light = 3'b001;
        START:   state_light = 3'b010;
        default: state_light = 3'b100;
      endcase
    end
  end

endmodule

// File: tb/tb_manual_drive_ctrl.sv
// Bench for manual_drive_ctrl: directed scenarios plus random driving, all
// compared cycle by cycle against a behavioural model of the car controller.
module tb_manual_drive_ctrl;

  localparam int CLK_PER_MS  = 4;
  localparam int POWER_ON_MS = 5;
  localparam int IDLE_MS     = 8;
  localparam int BLINK_MS    = 2;
  localparam int MILEAGE_MS  = 3;
  localparam int MILEAGE_W   = 4;
  localparam int MILE_MAX    = (1 << MILEAGE_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic power_on = 1'b0, power_off = 1'b0, clutch = 1'b0, brake = 1'b0;
  logic throttle = 1'b0, rgs = 1'b0, left = 1'b0, right = 1'b0;
  logic                 power;
  logic [1:0]           state;
  logic [3:0]           moving_state;
  logic                 turn_left_light, turn_right_light, power_light;
  logic [2:0]           state_light;
  logic [3:0]           moving_light;
  logic [MILEAGE_W-1:0] mileage;

  manual_drive_ctrl #(
    .CLK_PER_MS (CLK_PER_MS),
    .POWER_ON_MS(POWER_ON_MS),
    .IDLE_MS    (IDLE_MS),
    .BLINK_MS   (BLINK_MS),
    .MILEAGE_MS (MILEAGE_MS),
    .MILEAGE_W  (MILEAGE_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .power_on        (power_on),
    .power_off       (power_off),
    .clutch          (clutch),
    .brake           (brake),
    .throttle        (throttle),
    .rgs             (rgs),
    .left            (left),
    .right           (right),
    .power           (power),
    .state           (state),
    .moving_state    (moving_state),
    .turn_left_light (turn_left_light),
    .turn_right_light(turn_right_light),
    .power_light     (power_light),
    .state_light     (state_light),
    .moving_light    (moving_light),
    .mileage         (mileage)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: clocks since reset, consecutive hold ticks, idle ticks, ticks
  // since the current blink pattern began, total ticks spent moving.
  int m_cyc, m_hold, m_idle, m_bticks, m_move_ticks;
  bit m_power, m_bl_l, m_bl_r;
  int m_state, m_mv;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_hold = 0; m_idle = 0; m_bticks = 0; m_move_ticks = 0;
    m_power = 0; m_bl_l = 0; m_bl_r = 0; m_state = 0; m_mv = 0;
  endtask

  function automatic int dir_rule();
    if (rgs) return 2;
    if (left && !right) return 4;
    if (right && !left) return 8;
    return 1;
  endfunction

  task automatic model_step();
    bit tick, idle_run, idle_to, gl, gr, np;
    int ns, nm;
    m_cyc++;
    tick = (m_cyc % CLK_PER_MS) == 0;
    if (tick && m_state == 2 && m_mv != 0) m_move_ticks++;
    np = m_power; ns = m_state; nm = m_mv; gl = 0; gr = 0;
    if (!m_power) begin
      m_idle = 0;
      if (!power_on) m_hold = 0;
      else if (tick) m_hold++;
      if (m_hold == POWER_ON_MS) begin
        m_hold = 0; np = 1; ns = 0; nm = 0;
      end
    end else begin
      m_hold = 0;
      idle_run = !throttle && m_state != 2;
      idle_to = tick && idle_run && (m_idle + 1 == IDLE_MS);
      if (power_off || (m_state == 0 && throttle && !clutch) ||
          (m_state == 2 && rgs && !clutch) || idle_to) begin
        np = 0; ns = 0; nm = 0; m_idle = 0;
      end else begin
        if (!idle_run) m_idle = 0;
        else if (tick) m_idle++;
        case (m_state)
          0: begin
            nm = 0;
            if (!brake && throttle && clutch && !rgs) ns = 1;
          end
          1: begin
            nm = 0;
            if (brake) ns = 0;
            else if (throttle && !clutch) begin ns = 2; nm = dir_rule(); end
          end
          default: begin
            if (brake) begin ns = 0; nm = 0; end
            else if (!throttle) begin ns = 1; nm = 0; end
            else nm = dir_rule();
          end
        endcase
        if (ns == 2) begin
          gl = (nm == 4) || (nm == 1 && left && right);
          gr = (nm == 8) || (nm == 1 && left && right);
        end
      end
    end
    if (gl || gr) begin
      if (gl != m_bl_l || gr != m_bl_r) m_bticks = 0;
      else if (tick) m_bticks++;
    end
    m_bl_l = gl; m_bl_r = gr;
    m_power = np; m_state = ns; m_mv = nm;
  endtask

  task automatic check_all(input string tag);
    bit on;
    logic [2:0] sl;
    logic [3:0] ml;
    logic el, er;
    int mm;
    on = ((m_bticks / BLINK_MS) % 2) == 0;
    sl = m_power ? (3'b001 << m_state) : 3'b000;
    ml = m_power ? 4'(m_mv) : 4'b0000;
    el = m_power && (m_state == 0 || (m_bl_l && on));
    er = m_power && (m_state == 0 || (m_bl_r && on));
    mm = m_move_ticks / MILEAGE_MS;
    if (mm > MILE_MAX) mm = MILE_MAX;
    check_val({tag, ".power"}, 32'(power), 32'(m_power));
    check_val({tag, ".state"}, 32'(state), 32'(m_state));
    check_val({tag, ".moving_state"}, 32'(moving_state), 32'(m_mv));
    check_val({tag, ".power_light"}, 32'(power_light), 32'(m_power));
    check_val({tag, ".state_light"}, 32'(state_light), 32'(sl));
    check_val({tag, ".moving_light"}, 32'(moving_light), 32'(ml));
    check_val({tag, ".left_light"}, 32'(turn_left_light), 32'(el));
    check_val({tag, ".right_light"}, 32'(turn_right_light), 32'(er));
    check_val({tag, ".mileage"}, 32'(mileage), 32'(mm));
  endtask

  task automatic set_in(input bit po, input bit pf, input bit cl, input bit br,
                        input bit th, input bit rg, input bit l, input bit r);
    power_on = po; power_off = pf; clutch = cl; brake = br;
    throttle = th; rgs = rg; left = l; right = r;
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
    end
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    check_val("async_rst.mileage_zero", 32'(mileage), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic power_up_and_move(input bit l, input bit r);
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    run(20, "pwrup");
    check_val("pwrup.power", 32'(power), 32'd1);
    set_in(0, 0, 1, 0, 1, 0, 0, 0);
    run(1, "to_start");
    set_in(0, 0, 0, 0, 1, 0, l, r);
    run(1, "to_moving");
    check_val("to_moving.state_light", 32'(state_light), 32'b100);
  endtask

  initial begin
    model_reset();
    #1;
    check_all("reset");
    check_val("reset.state_light", 32'(state_light), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // power-up interrupted after 4 ticks, then 5 continuous ticks
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    run(16, "pu_hold");
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    run(1, "pu_release");
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    run(15, "pu_rehold");
    check_val("pu_not_yet", 32'(power), 32'd0);
    run(4, "pu_rehold");
    check_val("pu_done", 32'(power), 32'd1);
    check_val("pu_state_light", 32'(state_light), 32'b001);
    check_val("pu_left_steady", 32'(turn_left_light), 32'd1);
    check_val("pu_right_steady", 32'(turn_right_light), 32'd1);

    // start, then drive with left indicator
    set_in(0, 0, 1, 0, 1, 0, 0, 0);
    run(1, "start");
    check_val("start.state_light", 32'(state_light), 32'b010);
    set_in(0, 0, 0, 0, 1, 0, 1, 0);
    run(1, "move_left");
    check_val("move_left.moving_light", 32'(moving_light), 32'b0100);
    check_val("move_left.first_on", 32'(turn_left_light), 32'd1);
    check_val("move_left.right_off", 32'(turn_right_light), 32'd0);
    run(24, "blink_left");

    // stall in MOVING via reverse gear without clutch
    set_in(0, 0, 0, 0, 1, 1, 0, 0);
    run(1, "stall");
    check_val("stall.power", 32'(power), 32'd0);
    check_val("stall.state_light", 32'(state_light), 32'd0);
    check_val("stall.moving_light", 32'(moving_light), 32'd0);

    // idle power-off with a throttle pulse restarting the count
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    run(20, "idle_pwrup");
    check_val("idle_pwrup.power", 32'(power), 32'd1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    run(28, "idle_7");
    check_val("idle_7.power", 32'(power), 32'd1);
    set_in(0, 0, 1, 0, 1, 1, 0, 0);
    run(1, "idle_pulse");
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    run(28, "idle_restart");
    check_val("idle_restart.power", 32'(power), 32'd1);
    run(4, "idle_timeout");
    check_val("idle_timeout.power", 32'(power), 32'd0);

    // mileage from a clean reset, then saturation, then async reset
    async_reset();
    power_up_and_move(0, 0);
    run(12, "mile_1");
    check_val("mile_1.mileage", 32'(mileage), 32'd1);
    run(180, "mile_sat");
    check_val("mile_sat.mileage", 32'(mileage), 32'(MILE_MAX));
    run(5, "mile_mid");
    async_reset();

    // hazard blink, then power_off beats brake
    power_up_and_move(1, 1);
    run(18, "hazard");
    set_in(0, 1, 0, 1, 1, 0, 0, 0);
    run(1, "prio");
    check_val("prio.power", 32'(power), 32'd0);
    check_val("prio.state_light", 32'(state_light), 32'd0);

    for (int seg = 0; seg < 400; seg++) begin
      set_in(m_power ? ($urandom_range(0, 99) < 5) : ($urandom_range(0, 99) < 92),
             $urandom_range(0, 99) < 3,
             $urandom_range(0, 99) < 50,
             $urandom_range(0, 99) < 10,
             $urandom_range(0, 99) < 65,
             $urandom_range(0, 99) < 10,
             $urandom_range(0, 99) < 35,
             $urandom_range(0, 99) < 35);
      run($urandom_range(1, 6), "rand");
      if ($urandom_range(0, 149) == 0) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
